// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit
// common-anode 7-segment display with one shared BCD decoder.
// Each slot is TICK_DIV cycles: BLANK_CYC dead-time cycles with all anodes
// off, then the digit's anode is driven low. A pending buffer takes new
// values at any time and they are copied into the shown value only at
// frame boundaries (or at once while idle).
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NDIG      = 4,
   parameter int TICK_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [4*NDIG-1:0] load_data,
   output logic [3:0]        digit_bcd,
   output logic [NDIG-1:0]   an_n,
   output logic              frame_done
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [DW-1:0]   DIV_LAST  = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0]   BLANK_END = DW'(BLANK_CYC);
   localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
   localparam logic [NDIG-1:0] ONE       = NDIG'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   // With no dead time a slot starts directly in SHOW.
   localparam logic [1:0] SLOT_ENTRY = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;

   logic [1:0]            state, nxt_state;
   logic [DW-1:0]         div, nxt_div;
   logic [IW-1:0]         idx, nxt_idx;
   logic [NDIG-1:0][3:0]  disp, pend, nxt_disp;
   logic                  pend_v;
   logic                  frame_end, xfer, accept;
   logic [NDIG-1:0]       blank;
   logic                  lead;

   assign load_ready = !pend_v;
   assign accept     = load_valid && !pend_v;
   assign frame_end  = (state != S_IDLE) && (div == DIV_LAST) && (idx == IDX_LAST);
   // Pending value moves to the display while idle or at a frame boundary.
   assign xfer       = pend_v && ((state == S_IDLE) || frame_end);
   assign nxt_disp   = xfer ? pend : disp;

   // Next scan position: slot counter, digit index and phase within the slot.
   always_comb begin
      nxt_state = state;
      nxt_div   = div;
      nxt_idx   = idx;
      if (!enable) begin
         nxt_state = S_IDLE;
         nxt_div   = '0;
         nxt_idx   = '0;
      end else if (state == S_IDLE) begin
         nxt_state = SLOT_ENTRY;
         nxt_div   = '0;
         nxt_idx   = '0;
      end else if (div == DIV_LAST) begin
         nxt_state = SLOT_ENTRY;
         nxt_div   = '0;
         nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         nxt_div = div + 1'b1;
         if (state == S_BLANK && nxt_div == BLANK_END)
            nxt_state = S_SHOW;
      end
   end

`ifdef SEG_SCAN_LZB_EN
   // Mark digits that are zero from the top down to the first nonzero digit;
   // digit 0 always stays visible.
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         lead     = lead && (nxt_disp[i] == 4'd0);
         blank[i] = lead;
      end
   end
`else
   // Every digit is shown.
   always_comb begin
      blank = '0;
      lead  = 1'b0;
   end
`endif

   // Scan state, buffers and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         div        <= '0;
         idx        <= '0;
         disp       <= '0;
         pend       <= '0;
         pend_v     <= 1'b0;
         an_n       <= '1;
         digit_bcd  <= 4'd0;
         frame_done <= 1'b0;
      end else begin
         state <= nxt_state;
         div   <= nxt_div;
         idx   <= nxt_idx;
         disp  <= nxt_disp;
         if (xfer)
            pend_v <= 1'b0;
         else if (accept) begin
            pend   <= load_data;
            pend_v <= 1'b1;
         end
         an_n       <= (nxt_state == S_SHOW && !blank[nxt_idx]) ? ~(ONE << nxt_idx) : '1;
         digit_bcd  <= (nxt_state == S_IDLE) ? 4'd0 : nxt_disp[nxt_idx];
         frame_done <= (nxt_state != S_IDLE) && (nxt_div == DIV_LAST) && (nxt_idx == IDX_LAST);
      end
   end

endmodule
